// File: rtl/ooo_fetch_decode_exec.sv
// ooo_fetch_decode_exec
//   Fetch/decode/execute datapath for the simple out-of-order core.
//   - Instruction ROM (8 x 10 bits): read combinationally; the image is loaded on a
//     rising clk edge while rst is low, and held while rst is high.
//   - Decoder: splits the fetched instruction into its raw fields and control bits.
//   - Execute lane: ALU (LI/ADD), result select against data memory, and branch
//     resolution with modulo-8 PC arithmetic.
// Ports
//   clk, rst                    clock, synchronous active-low reset (ROM image load)
//   req_addr / resp_data        fetch PC in, instruction out
//   opcode, rd, rs1_imm, rs1_br_offset, rs1, rs2   raw instruction slices
//   rs1_used, rs2_used, wen, rd_data_use_alu, mem_valid, is_br   decoded control
//   ex_*                        execute-lane operands in
//   mem_addr / mem_data         data-memory address out, read value in
//   ex_rd_data, ex_taken, ex_next_pc   execute results
module ooo_fetch_decode_exec #(
    parameter int unsigned MEMI_SIZE_LOG = 3,
    parameter int unsigned INST_LEN      = 10,
    parameter int unsigned REG_LEN       = 4,
    parameter int unsigned RF_SIZE_LOG   = 2,
    parameter int unsigned MEMD_SIZE_LOG = 2,
    parameter int unsigned OP_LEN        = 2
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [MEMI_SIZE_LOG-1:0] req_addr,
    output logic [INST_LEN-1:0]      resp_data,

    output logic [OP_LEN-1:0]        opcode,
    output logic [RF_SIZE_LOG-1:0]   rd,
    output logic [REG_LEN-1:0]       rs1_imm,
    output logic [MEMI_SIZE_LOG-1:0] rs1_br_offset,
    output logic [RF_SIZE_LOG-1:0]   rs1,
    output logic [RF_SIZE_LOG-1:0]   rs2,
    output logic                     rs1_used,
    output logic                     rs2_used,
    output logic                     wen,
    output logic                     rd_data_use_alu,
    output logic                     mem_valid,
    output logic                     is_br,

    input  logic [MEMI_SIZE_LOG-1:0] ex_pc,
    input  logic [OP_LEN-1:0]        ex_op,
    input  logic [REG_LEN-1:0]       ex_imm,
    input  logic [MEMI_SIZE_LOG-1:0] ex_br_offset,
    input  logic [REG_LEN-1:0]       ex_rs1_data,
    input  logic [REG_LEN-1:0]       ex_rs2_data,
    input  logic                     ex_use_alu,
    input  logic                     ex_is_br,

    output logic [MEMD_SIZE_LOG-1:0] mem_addr,
    input  logic [REG_LEN-1:0]       mem_data,

    output logic [REG_LEN-1:0]       ex_rd_data,
    output logic                     ex_taken,
    output logic [MEMI_SIZE_LOG-1:0] ex_next_pc
);

    localparam int unsigned MemiDepth = 1 << MEMI_SIZE_LOG;

    localparam logic [OP_LEN-1:0] OpLi  = 2'd0;
    localparam logic [OP_LEN-1:0] OpAdd = 2'd1;
    localparam logic [OP_LEN-1:0] OpLd  = 2'd2;
    localparam logic [OP_LEN-1:0] OpBr  = 2'd3;

    // ------------------------------------------------------------------
    // Instruction ROM
    // ------------------------------------------------------------------
    logic [INST_LEN-1:0] memi [MemiDepth];

    always_ff @(posedge clk) begin
        if (!rst) begin
            memi[0] <= 10'b00_01_0001_00;  // LI  r1, 1
            memi[1] <= 10'b10_10_0001_00;  // LD  r2, [r1]
            memi[2] <= 10'b01_11_0001_10;  // ADD r3, r1, r2
            memi[3] <= 10'b11_00_0101_00;  // BR  r0, +5
            for (int i = 4; i < MemiDepth; i++) begin
                memi[i] <= '0;             // LI r0, 0
            end
        end
    end

    assign resp_data = memi[req_addr];

    // ------------------------------------------------------------------
    // Decode: field outputs are raw slices regardless of opcode
    // ------------------------------------------------------------------
    assign opcode        = resp_data[9:8];
    assign rd            = resp_data[7:6];
    assign rs1_imm       = resp_data[5:2];
    assign rs1_br_offset = resp_data[4:2];
    assign rs1           = resp_data[3:2];
    assign rs2           = resp_data[1:0];

    always_comb begin
        rs1_used        = 1'b0;
        rs2_used        = 1'b0;
        wen             = 1'b0;
        rd_data_use_alu = 1'b0;
        mem_valid       = 1'b0;
        is_br           = 1'b0;
        unique case (opcode)
            OpLi: begin
                wen             = 1'b1;
                rd_data_use_alu = 1'b1;
            end
            OpAdd: begin
                rs1_used        = 1'b1;
                rs2_used        = 1'b1;
                wen             = 1'b1;
                rd_data_use_alu = 1'b1;
            end
            OpLd: begin
                rs1_used  = 1'b1;
                wen       = 1'b1;
                mem_valid = 1'b1;
            end
            OpBr: begin
                rs2_used = 1'b1;
                is_br    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Execute lane
    // ------------------------------------------------------------------
    logic [REG_LEN-1:0] alu_res;

    always_comb begin
        alu_res = '0;
        unique case (ex_op)
            OpLi:    alu_res = ex_imm;
            OpAdd:   alu_res = ex_rs1_data + ex_rs2_data;  // wraps at REG_LEN bits
            OpLd:    alu_res = '0;
            OpBr:    alu_res = '0;
        endcase
    end

    assign mem_addr   = ex_rs1_data[MEMD_SIZE_LOG-1:0];
    assign ex_rd_data = ex_use_alu ? alu_res : mem_data;
    assign ex_taken   = ex_is_br && (ex_rs2_data == '0);
    // PC width truncation gives the modulo-8 wrap
    assign ex_next_pc = ex_taken ? (ex_pc + ex_br_offset) : (ex_pc + 3'd1);

endmodule

// File: tb/tb_ooo_fetch_decode_exec.sv
module tb_ooo_fetch_decode_exec;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] req_addr = '0;
    logic [9:0] resp_data;
    logic [1:0] opcode, rd, rs1, rs2;
    logic [3:0] rs1_imm;
    logic [2:0] rs1_br_offset;
    logic       rs1_used, rs2_used, wen, rd_data_use_alu, mem_valid, is_br;
    logic [2:0] ex_pc = '0;
    logic [1:0] ex_op = '0;
    logic [3:0] ex_imm = '0;
    logic [2:0] ex_br_offset = '0;
    logic [3:0] ex_rs1_data = '0, ex_rs2_data = '0;
    logic       ex_use_alu = 1'b0, ex_is_br = 1'b0;
    logic [1:0] mem_addr;
    logic [3:0] mem_data = '0;
    logic [3:0] ex_rd_data;
    logic       ex_taken;
    logic [2:0] ex_next_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ooo_fetch_decode_exec dut (
        .clk             (clk),
        .rst             (rst),
        .req_addr        (req_addr),
        .resp_data       (resp_data),
        .opcode          (opcode),
        .rd              (rd),
        .rs1_imm         (rs1_imm),
        .rs1_br_offset   (rs1_br_offset),
        .rs1             (rs1),
        .rs2             (rs2),
        .rs1_used        (rs1_used),
        .rs2_used        (rs2_used),
        .wen             (wen),
        .rd_data_use_alu (rd_data_use_alu),
        .mem_valid       (mem_valid),
        .is_br           (is_br),
        .ex_pc           (ex_pc),
        .ex_op           (ex_op),
        .ex_imm          (ex_imm),
        .ex_br_offset    (ex_br_offset),
        .ex_rs1_data     (ex_rs1_data),
        .ex_rs2_data     (ex_rs2_data),
        .ex_use_alu      (ex_use_alu),
        .ex_is_br        (ex_is_br),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .ex_rd_data      (ex_rd_data),
        .ex_taken        (ex_taken),
        .ex_next_pc      (ex_next_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference ROM image and per-opcode control table
    // {rs1_used, rs2_used, wen, use_alu, mem_valid, is_br}
    logic [9:0] image [8];
    logic [5:0] ctrl_tab [4];

    task automatic check_fetch(input int a);
        logic [9:0] inst;
        logic [5:0] c;
        req_addr = 3'(a);
        #1;
        inst = image[a];
        c = ctrl_tab[inst[9:8]];
        check($sformatf("resp_data[%0d]", a), 32'(resp_data), 32'(inst));
        check("opcode", 32'(opcode), 32'(inst[9:8]));
        check("rd", 32'(rd), 32'(inst[7:6]));
        check("rs1_imm", 32'(rs1_imm), 32'(inst[5:2]));
        check("rs1_br_offset", 32'(rs1_br_offset), 32'(inst[4:2]));
        check("rs1", 32'(rs1), 32'(inst[3:2]));
        check("rs2", 32'(rs2), 32'(inst[1:0]));
        check("ctrl", 32'({rs1_used, rs2_used, wen, rd_data_use_alu, mem_valid, is_br}),
              32'(c));
    endtask

    task automatic run_ex(input int pc, input int op, input int imm, input int off,
                          input int a, input int b, input bit use_alu, input bit br,
                          input int md);
        int alu, res, nxt;
        bit tk;
        ex_pc = 3'(pc); ex_op = 2'(op); ex_imm = 4'(imm); ex_br_offset = 3'(off);
        ex_rs1_data = 4'(a); ex_rs2_data = 4'(b); ex_use_alu = use_alu; ex_is_br = br;
        mem_data = 4'(md);
        #1;
        if (op == 0)      alu = imm;
        else if (op == 1) alu = (a + b) % 16;
        else              alu = 0;
        res = use_alu ? alu : md;
        tk  = br && (b == 0);
        nxt = tk ? (pc + off) % 8 : (pc + 1) % 8;
        check("mem_addr", 32'(mem_addr), 32'(a % 4));
        check("ex_rd_data", 32'(ex_rd_data), 32'(res));
        check("ex_taken", 32'(ex_taken), 32'(tk));
        check("ex_next_pc", 32'(ex_next_pc), 32'(nxt));
    endtask

    initial begin
        image[0] = 10'b00_01_0001_00;
        image[1] = 10'b10_10_0001_00;
        image[2] = 10'b01_11_0001_10;
        image[3] = 10'b11_00_0101_00;
        for (int i = 4; i < 8; i++) image[i] = '0;
        ctrl_tab[0] = 6'b001100;
        ctrl_tab[1] = 6'b111100;
        ctrl_tab[2] = 6'b101010;
        ctrl_tab[3] = 6'b010001;

        // Reset load on the first edge
        @(negedge clk);
        rst = 1'b1;
        for (int a = 0; a < 8; a++) check_fetch(a);

        // Spot checks from the decoded image
        req_addr = 3'd0; #1;
        check("li_rd", 32'(rd), 32'd1);
        check("li_imm", 32'(rs1_imm), 32'd1);
        req_addr = 3'd1; #1;
        check("ld_mem_valid", 32'(mem_valid), 32'd1);
        check("ld_rs1", 32'(rs1), 32'd1);
        check("ld_rd", 32'(rd), 32'd2);
        req_addr = 3'd3; #1;
        check("br_is_br", 32'(is_br), 32'd1);
        check("br_wen", 32'(wen), 32'd0);
        check("br_offset", 32'(rs1_br_offset), 32'd5);

        // Directed execute cases
        run_ex(2, 1, 0, 0, 9, 8, 1, 0, 0);    // ADD wrap -> 1
        check("add_wrap", 32'(ex_rd_data), 32'd1);
        run_ex(1, 2, 0, 0, 6, 0, 0, 0, 10);   // LD
        check("ld_addr", 32'(mem_addr), 32'd2);
        check("ld_data", 32'(ex_rd_data), 32'hA);
        run_ex(3, 3, 0, 5, 0, 0, 0, 1, 0);    // BR taken wraps to 0
        check("br_taken_pc", 32'(ex_next_pc), 32'd0);
        run_ex(3, 3, 0, 5, 0, 4, 0, 1, 0);    // BR not taken
        check("br_nt_pc", 32'(ex_next_pc), 32'd4);
        run_ex(7, 0, 3, 2, 0, 0, 1, 0, 5);    // non-branch pc wrap
        check("pc_wrap", 32'(ex_next_pc), 32'd0);
        check("li_res", 32'(ex_rd_data), 32'd3);

        // Randomized execute and fetch
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            run_ex(int'($urandom_range(7)), int'($urandom_range(3)), int'($urandom_range(15)),
                   int'($urandom_range(7)), int'($urandom_range(15)),
                   ($urandom_range(3) == 0) ? 0 : int'($urandom_range(15)),
                   1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(15)));
            check_fetch(int'($urandom_range(7)));
        end

        // Mid-run reset reloads the same image; held afterwards
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int a = 0; a < 8; a++) check_fetch(a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
